id_stage: RTL and testbench

Decode stage of the five-stage MIPS pipeline, directly downstream of the instruction fetch unit. Holds the IF/ID pipeline register and the 32×32 general register file (GRF). Resolves beq/j/jal/jr in D with forwarded operands, and drives the fetch unit's B/offset/J/index/Jr/addr inputs in the same cycle. Also presents register operands, extended immediate, instruction and PC+8 to the execute stage.

---
 rtl/id_stage_pkg.sv | 49 ++++
 rtl/id_stage_grf.sv | 61 ++++++
 rtl/id_stage.sv | 122 ++++++++++++
 tb/tb_id_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pkg
//  Description : Shared opcode/funct constants, forwarding encodings and
//                decode helper for the decode stage and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_stage_pkg;

    localparam logic [5:0] c_op_special = 6'b000000;
    localparam logic [5:0] c_op_beq     = 6'b000100;
    localparam logic [5:0] c_op_j       = 6'b000010;
    localparam logic [5:0] c_op_jal     = 6'b000011;
    localparam logic [5:0] c_op_ori     = 6'b001101;
    localparam logic [5:0] c_op_lui     = 6'b001111;
    localparam logic [5:0] c_funct_jr   = 6'b001000;

    localparam logic [1:0] c_fwd_grf = 2'd0;
    localparam logic [1:0] c_fwd_e   = 2'd1;
    localparam logic [1:0] c_fwd_m   = 2'd2;

    localparam logic [31:0] c_reset_pc = 32'h0000_3000;

    typedef struct packed {
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic ori;
        logic lui;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] funct;
        op     = instr[31:26];
        funct  = instr[5:0];
        d.beq  = (op == c_op_beq);
        d.j    = (op == c_op_j);
        d.jal  = (op == c_op_jal);
        d.jr   = (op == c_op_special) && (funct == c_funct_jr);
        d.ori  = (op == c_op_ori);
        d.lui  = (op == c_op_lui);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_grf.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_grf
//  Description : 32x32 general register file, two combinational read ports
//                with write-through bypass; $0 is hard-wired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_grf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_w_en,
    input  logic [4:0]  i_w_addr,
    input  logic [31:0] i_w_data,
    input  logic [4:0]  i_ra_addr,
    input  logic [4:0]  i_rb_addr,
    output logic [31:0] o_ra_data,
    output logic [31:0] o_rb_data
);

    logic [31:0][31:0] regs_q;
    logic [31:0][31:0] regs_d;
    logic              w_wr;

    assign w_wr = i_w_en && (i_w_addr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (w_wr) begin
            regs_d[i_w_addr] = i_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets write-back and decode share a cycle without a hazard stall.
    always_comb begin
        if (i_ra_addr == 5'd0) begin
            o_ra_data = 32'd0;
        end else if (w_wr && (i_w_addr == i_ra_addr)) begin
            o_ra_data = i_w_data;
        end else begin
            o_ra_data = regs_q[i_ra_addr];
        end

        if (i_rb_addr == 5'd0) begin
            o_rb_data = 32'd0;
        end else if (w_wr && (i_w_addr == i_rb_addr)) begin
            o_rb_data = i_w_data;
        end else begin
            o_rb_data = regs_q[i_rb_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : MIPS decode stage - IF/ID register, GRF, operand forwarding,
//                branch/jump resolution and immediate extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc8_f,
    input  logic        w_en,
    input  logic [4:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic [1:0]  fwd_rs_sel,
    input  logic [1:0]  fwd_rt_sel,
    input  logic [31:0] fwd_e_data,
    input  logic [31:0] fwd_m_data,
    output logic        B,
    output logic [31:0] offset,
    output logic        J,
    output logic [25:0] index,
    output logic        Jr,
    output logic [31:0] addr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext
);

    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q,    ifid_pc_d;
    logic [31:0] ifid_pc8_q,   ifid_pc8_d;

    logic [31:0] w_grf_rs;
    logic [31:0] w_grf_rt;
    logic [15:0] w_imm16;
    dec_t        w_dec;

    always_comb begin
        ifid_instr_d = stall ? ifid_instr_q : instr_f;
        ifid_pc_d    = stall ? ifid_pc_q    : pc_f;
        ifid_pc8_d   = stall ? ifid_pc8_q   : pc8_f;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= RESET_PC;
            ifid_pc8_q   <= RESET_PC + 32'd8;
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc8_q   <= ifid_pc8_d;
        end
    end

    assign instr_d = ifid_instr_q;
    assign pc_d    = ifid_pc_q;
    assign pc8_d   = ifid_pc8_q;
    assign rs_addr = ifid_instr_q[25:21];
    assign rt_addr = ifid_instr_q[20:16];
    assign w_imm16 = ifid_instr_q[15:0];

    id_stage_grf u_grf (
        .clk       (clk),
        .rst       (reset),
        .i_w_en    (w_en),
        .i_w_addr  (w_addr),
        .i_w_data  (w_data),
        .i_ra_addr (rs_addr),
        .i_rb_addr (rt_addr),
        .o_ra_data (w_grf_rs),
        .o_rb_data (w_grf_rt)
    );

    always_comb begin
        case (fwd_rs_sel)
            c_fwd_e: rs_data = fwd_e_data;
            c_fwd_m: rs_data = fwd_m_data;
            default: rs_data = w_grf_rs;
        endcase
        case (fwd_rt_sel)
            c_fwd_e: rt_data = fwd_e_data;
            c_fwd_m: rt_data = fwd_m_data;
            default: rt_data = w_grf_rt;
        endcase
    end

    assign w_dec = decode(ifid_instr_q);

    // A stalled branch must not redirect fetch; it re-resolves once released.
    assign B      = w_dec.beq && (rs_data == rt_data) && !stall;
    assign J      = (w_dec.j || w_dec.jal) && !stall;
    assign Jr     = w_dec.jr && !stall;
    assign addr   = rs_data;
    assign offset = {{14{w_imm16[15]}}, w_imm16, 2'b00};
    assign index  = ifid_instr_q[25:0];

    always_comb begin
        if (w_dec.ori) begin
            imm_ext = {16'd0, w_imm16};
        end else if (w_dec.lui) begin
            imm_ext = {w_imm16, 16'd0};
        end else begin
            imm_ext = {{16{w_imm16[15]}}, w_imm16};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Directed self-checking bench for the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] instr_f, pc_f, pc8_f;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] fwd_e_data, fwd_m_data;
    logic        B, J, Jr;
    logic [31:0] offset, addr, instr_d, pc_d, pc8_d, rs_data, rt_data, imm_ext;
    logic [25:0] index;
    logic [4:0]  rs_addr, rt_addr;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] c_beq   = 32'h1022_0003; // beq $1,$2,+3
    localparam logic [31:0] c_jr31  = 32'h03E0_0008; // jr $31
    localparam logic [31:0] c_ori   = 32'h3405_8000; // ori $5,$0,0x8000
    localparam logic [31:0] c_lui   = 32'h3C06_1234; // lui $6,0x1234
    localparam logic [31:0] c_addiu = 32'h2407_FFFF; // addiu $7,$0,-1
    localparam logic [31:0] c_j     = 32'h0800_0010;
    localparam logic [31:0] c_jal   = 32'h0C00_0020;

    always #5 clk = ~clk;

    id_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .instr_f(instr_f), .pc_f(pc_f), .pc8_f(pc8_f),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .fwd_e_data(fwd_e_data), .fwd_m_data(fwd_m_data),
        .B(B), .offset(offset), .J(J), .index(index), .Jr(Jr), .addr(addr),
        .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; instr_f = c_beq; pc_f = 32'h100; pc8_f = 32'h108;
        w_en = 1'b0; w_addr = 5'd0; w_data = 32'd0;
        fwd_rs_sel = 2'd0; fwd_rt_sel = 2'd0; fwd_e_data = 32'd0; fwd_m_data = 32'd0;
        tick();
        reset = 1'b0;
        n_cmp++; if (instr_d !== 32'd0) begin n_err++; $display("FAIL reset_instr_d got %h want 0", instr_d); end
        n_cmp++; if (pc_d !== 32'h3000) begin n_err++; $display("FAIL reset_pc_d got %h want 3000", pc_d); end
        n_cmp++; if (pc8_d !== 32'h3008) begin n_err++; $display("FAIL reset_pc8_d got %h want 3008", pc8_d); end
        n_cmp++; if ({B, J, Jr} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got %b want 000", {B, J, Jr}); end
        n_cmp++; if ({offset, imm_ext, 6'd0, index} !== 96'd0) begin n_err++; $display("FAIL reset_imm got %h %h %h want 0", offset, imm_ext, index); end
        n_cmp++; if ({rs_data, rt_data} !== 64'd0) begin n_err++; $display("FAIL reset_ops got %h %h want 0", rs_data, rt_data); end
    endtask

    task automatic test_beq();
        w_en = 1'b1; w_addr = 5'd1; w_data = 32'd5;
        tick();
        w_addr = 5'd2; instr_f = c_beq; pc_f = 32'h3010; pc8_f = 32'h3018;
        tick();
        w_en = 1'b0;
        #1;
        n_cmp++; if (B !== 1'b1) begin n_err++; $display("FAIL beq_taken got %b want 1", B); end
        n_cmp++; if (offset !== 32'h0000_000C) begin n_err++; $display("FAIL beq_offset got %h want 0000000c", offset); end
        n_cmp++; if ({rs_data, rt_data} !== {32'd5, 32'd5}) begin n_err++; $display("FAIL beq_ops got %h %h want 5 5", rs_data, rt_data); end
        n_cmp++; if ({rs_addr, rt_addr, pc_d} !== {5'd1, 5'd2, 32'h3010}) begin n_err++; $display("FAIL beq_fields got %0d %0d %h want 1 2 3010", rs_addr, rt_addr, pc_d); end
    endtask

    task automatic test_fwd();
        fwd_rs_sel = 2'd1; fwd_e_data = 32'd7; #1;
        n_cmp++; if ({B, rs_data} !== {1'b0, 32'd7}) begin n_err++; $display("FAIL fwd_e_7 got B=%b rs=%h want 0 7", B, rs_data); end
        fwd_e_data = 32'd5; #1;
        n_cmp++; if (B !== 1'b1) begin n_err++; $display("FAIL fwd_e_5 got %b want 1", B); end
        fwd_rs_sel = 2'd2; fwd_m_data = 32'd9; #1;
        n_cmp++; if ({B, rs_data} !== {1'b0, 32'd9}) begin n_err++; $display("FAIL fwd_m got B=%b rs=%h want 0 9", B, rs_data); end
        fwd_rs_sel = 2'd3; fwd_rt_sel = 2'd2; fwd_m_data = 32'd5; #1;
        n_cmp++; if ({B, rs_data, rt_data} !== {1'b1, 32'd5, 32'd5}) begin n_err++; $display("FAIL fwd_sel3 got B=%b rs=%h rt=%h want 1 5 5", B, rs_data, rt_data); end
        fwd_rs_sel = 2'd0; fwd_rt_sel = 2'd0;
    endtask

    task automatic test_jr_bypass();
        instr_f = c_jr31;
        tick();
        w_en = 1'b1; w_addr = 5'd31; w_data = 32'h0000_3040; #1;
        n_cmp++; if ({Jr, B, J} !== 3'b100) begin n_err++; $display("FAIL jr_ctrl got %b want 100", {Jr, B, J}); end
        n_cmp++; if (addr !== 32'h0000_3040) begin n_err++; $display("FAIL jr_addr got %h want 00003040", addr); end
        tick();
        w_en = 1'b0; #1;
        n_cmp++; if (addr !== 32'h0000_3040) begin n_err++; $display("FAIL jr_stored got %h want 00003040", addr); end
    endtask

    task automatic test_stall();
        instr_f = c_beq; pc_f = 32'h3020; pc8_f = 32'h3028;
        tick();
        stall = 1'b1; instr_f = c_ori; pc_f = 32'h3024; pc8_f = 32'h302C;
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h55; #1;
        n_cmp++; if (B !== 1'b0) begin n_err++; $display("FAIL stall_B0 got %b want 0", B); end
        for (int i = 0; i < 3; i++) begin
            tick();
            w_en = 1'b0;
            n_cmp++; if ({instr_d, pc_d, B} !== {c_beq, 32'h3020, 1'b0}) begin n_err++; $display("FAIL stall_hold%0d got %h %h B=%b want %h 3020 0", i, instr_d, pc_d, B, c_beq); end
        end
        stall = 1'b0; #1;
        n_cmp++; if (B !== 1'b1) begin n_err++; $display("FAIL stall_release got %b want 1", B); end
        tick();
        n_cmp++; if ({instr_d, pc_d, B} !== {c_ori, 32'h3024, 1'b0}) begin n_err++; $display("FAIL stall_next got %h %h B=%b want %h 3024 0", instr_d, pc_d, B, c_ori); end
    endtask

    task automatic test_zero_imm();
        // instr_d is ori $5,$0,0x8000 here; $0 write must not bypass.
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF; #1;
        n_cmp++; if (rs_data !== 32'd0) begin n_err++; $display("FAIL zero_bypass got %h want 0", rs_data); end
        tick();
        w_en = 1'b0; #1;
        n_cmp++; if (rs_data !== 32'd0) begin n_err++; $display("FAIL zero_store got %h want 0", rs_data); end
        n_cmp++; if (imm_ext !== 32'h0000_8000) begin n_err++; $display("FAIL imm_ori got %h want 00008000", imm_ext); end
        instr_f = c_lui; tick();
        n_cmp++; if (imm_ext !== 32'h1234_0000) begin n_err++; $display("FAIL imm_lui got %h want 12340000", imm_ext); end
        instr_f = c_addiu; tick();
        n_cmp++; if (imm_ext !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL imm_addiu got %h want ffffffff", imm_ext); end
        instr_f = c_j; tick();
        n_cmp++; if ({J, Jr, B, index} !== {3'b100, 26'h10}) begin n_err++; $display("FAIL j_dec got J=%b Jr=%b B=%b idx=%h want 1 0 0 10", J, Jr, B, index); end
        instr_f = c_jal; tick();
        n_cmp++; if ({J, index} !== {1'b1, 26'h20}) begin n_err++; $display("FAIL jal_dec got J=%b idx=%h want 1 20", J, index); end
        stall = 1'b1; #1;
        n_cmp++; if (J !== 1'b0) begin n_err++; $display("FAIL jal_stall got %b want 0", J); end
        stall = 1'b0;
    endtask

    task automatic test_stall_write();
        // $3 was written while stalled; read it back through rs.
        instr_f = 32'h0060_0008; tick(); // jr $3
        n_cmp++; if (addr !== 32'h55) begin n_err++; $display("FAIL stall_write got %h want 55", addr); end
    endtask

    task automatic test_reset_mid();
        instr_f = c_beq; tick();
        stall = 1'b1; reset = 1'b1; tick();
        reset = 1'b0; stall = 1'b0;
        n_cmp++; if ({instr_d, pc_d} !== {32'd0, 32'h3000}) begin n_err++; $display("FAIL rmid_regs got %h %h want 0 3000", instr_d, pc_d); end
        instr_f = c_beq; tick();
        n_cmp++; if ({rs_data, rt_data} !== 64'd0) begin n_err++; $display("FAIL rmid_grf12 got %h %h want 0 0", rs_data, rt_data); end
        instr_f = c_jr31; tick();
        n_cmp++; if (addr !== 32'd0) begin n_err++; $display("FAIL rmid_grf31 got %h want 0", addr); end
        instr_f = 32'h0060_0008; tick();
        n_cmp++; if (addr !== 32'd0) begin n_err++; $display("FAIL rmid_grf3 got %h want 0", addr); end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_fwd();
        test_jr_bypass();
        test_stall();
        test_zero_imm();
        test_stall_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
